// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter and receiver state enums, default
// oversampling ratio and the baud divider helper.
package uart_pkg;

    // Default number of sample ticks per bit period
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Transmitter state encoding
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Receiver state encoding
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Clocks per sample tick, rounded to nearest and never below 1
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int div;
        div = (clk_hz + (baud * os) / 2) / (baud * os);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-side port bundle of the UART receiver: parallel data with a
// valid/ready handshake, error pulses and the busy flag.
// Optional parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    // Receiver drives the byte and status, consumer drives ready
    modport master (output data, valid, frame_err, overrun_err, busy, parity_err,
                    input  ready);
    modport slave  (input  data, valid, frame_err, overrun_err, busy, parity_err,
                    output ready);
`else
    // Receiver drives the byte and status, consumer drives ready
    modport master (output data, valid, frame_err, overrun_err, busy,
                    input  ready);
    modport slave  (input  data, valid, frame_err, overrun_err, busy,
                    output ready);
`endif

endinterface

// File: rtl/uart_rx_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks.
// restart re-aligns the divider so the first tick of a frame lands a full
// DIV clocks after the start edge was seen.
module uart_rx_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign tick = (div_cnt_q == LAST);

    // Count up to LAST and wrap, or jump back to zero on restart
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (restart || (div_cnt_q == LAST)) begin
            div_cnt_d = '0;
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronises rx, oversamples it, checks start/stop framing
// and hands each byte out over a valid/ready port with overrun detection.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_receiver_if.master rx_if
);

    localparam int            DIV       = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_DONE  = BW'(DATA_BITS);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 rx_prev_q, rx_prev_d;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 parity_err_q, parity_err_d;
`endif

    logic rx_s;
    logic fall_edge;
    logic tick;
    logic restart;
    logic commit;

    assign rx_s      = sync2_q;
    assign fall_edge = rx_prev_q & ~rx_s;

    uart_rx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state logic for the synchroniser, frame FSM and byte handshake
    always_comb begin
        sync1_d       = rx;
        sync2_d       = sync1_q;
        rx_prev_d     = sync2_q;
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        valid_d       = valid_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        restart       = 1'b0;
        commit        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d     = par_bit_q;
        parity_err_d  = 1'b0;
`endif

        if (valid_q && rx_if.ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            RX_IDLE: begin
                if (fall_edge) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                    restart    = 1'b1;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = RX_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = BIT_DONE;
`ifdef UART_RX_PARITY_EN
                            state_d   = RX_PARITY;
`else
                            state_d   = RX_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        par_bit_d  = rx_s;
                        state_d    = RX_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            commit  = 1'b1;
                            state_d = RX_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = RX_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // A held byte the consumer has not taken wins over the new one
        if (commit) begin
            if (!valid_q || rx_if.ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_d = ^{shift_q, par_bit_q};
`endif
        end

        busy_d = (state_d != RX_IDLE);
    end

    // State and registered outputs; the synchroniser resets to the idle level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= RX_IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_prev_q     <= rx_prev_d;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= par_bit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_if.data        = data_q;
    assign rx_if.valid       = valid_q;
    assign rx_if.frame_err   = frame_err_q;
    assign rx_if.overrun_err = overrun_err_q;
    assign rx_if.busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver at 16 clocks per bit (DIV=1).
// Frames are driven serially; expected bytes go into a queue that a
// separate monitor drains on every valid&&ready transfer.
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_receiver;

    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM  = 172;
`else
    localparam int LAT_NOM  = 156;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;

    uart_receiver_if #(.DATA_BITS(8)) bus ();

    uart_receiver #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD_RATE   (100_000),
        .OVERSAMPLE  (16),
        .DATA_BITS   (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .rx_if (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_q[$];
    int         exp_frame_err  = 0;
    int         exp_overrun    = 0;
    int         exp_parity_err = 0;
    int         seen_frame_err  = 0;
    int         seen_overrun    = 0;
    int         seen_parity_err = 0;
    int         seen_valid_cycles = 0;
    int         seen_transfers    = 0;
    int         rdy_mode = 0;
    bit         holding  = 1'b0;

    // One comparison: counts it and reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model of one good frame: a consumer that is not reading keeps
    // the first byte and every later byte is lost as an overrun
    task automatic modelCommit(input logic [7:0] b);
        if (holding) begin
            exp_overrun++;
        end else begin
            exp_q.push_back(b);
            if (rdy_mode == 1) holding = 1'b1;
        end
    endtask

    // Advance one clock; inputs change just after the rising edge
    task automatic stepClk();
        @(posedge clk);
        #1;
        if (rdy_mode == 2) bus.ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) stepClk();
    endtask

    task automatic driveBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) stepClk();
    endtask

    // Serialise one frame LSB first, then return the line to idle
    task automatic driveFrame(input logic [7:0] b, input logic par_bit,
                              input logic stop_bit, input bit with_par);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
        if (with_par) driveBit(par_bit);
        driveBit(stop_bit);
        rx = 1'b1;
    endtask

    // Send a frame with correct parity (when enabled) and a chosen stop bit
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) modelCommit(b);
        else          exp_frame_err++;
`ifdef UART_RX_PARITY_EN
        driveFrame(b, ^b, stop_bit, 1'b1);
`else
        driveFrame(b, 1'b0, stop_bit, 1'b0);
`endif
    endtask

    // Monitor: counts pulses, checks data stability while held, and pops the
    // scoreboard on every transfer
    initial begin
        logic       prev_hold;
        logic [7:0] prev_data;
        logic [7:0] exp_b;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_hold = 1'b0;
            end else begin
                if (bus.frame_err)   seen_frame_err++;
                if (bus.overrun_err) seen_overrun++;
`ifdef UART_RX_PARITY_EN
                if (bus.parity_err)  seen_parity_err++;
`endif
                if (bus.valid) seen_valid_cycles++;
                if (prev_hold && bus.valid) checkOutput("data_stable", bus.data, prev_data);
                if (bus.valid && bus.ready) begin
                    seen_transfers++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_valid", bus.valid, 1'b0);
                    end else begin
                        exp_b = exp_q.pop_front();
                        checkOutput("rx_data", bus.data, exp_b);
                    end
                end
                prev_hold = bus.valid && !bus.ready;
                prev_data = bus.data;
            end
        end
    end

    // Watchdog so a stuck design still ends the run
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized stream
    initial begin
        int         n;
        int         cnt;
        int         base_valid;
        int         base_xfer;
        bit         saw_busy;
        logic [7:0] rb;
        logic       rstop;

        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data",    bus.data, 8'h00);
        checkOutput("reset_valid",   bus.valid, 1'b0);
        checkOutput("reset_busy",    bus.busy, 1'b0);
        checkOutput("reset_frame",   bus.frame_err, 1'b0);
        checkOutput("reset_overrun", bus.overrun_err, 1'b0);
        rst = 1'b1;
        idle(20);

        // Single byte with latency and one-clock valid
        $display("[TB] single byte 0xA5");
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                n = 0;
                while (!bus.valid && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("a5_latency_ok", (n >= LAT_NOM - 6) && (n <= LAT_NOM + 6), 1'b1);
                @(negedge clk);
                checkOutput("a5_valid_one_clk", bus.valid, 1'b0);
            end
        join
        idle(20);
        checkOutput("a5_frame_err", seen_frame_err, exp_frame_err);
        checkOutput("a5_overrun",   seen_overrun, exp_overrun);

        // Short low glitch is rejected at the start-bit mid-sample;
        // two sync flops and the edge flop precede the half-bit wait
        $display("[TB] start glitch");
        base_valid = seen_valid_cycles;
        saw_busy = 1'b0;
        cnt = 0;
        rx = 1'b0;
        repeat (4) begin
            stepClk();
            cnt++;
            if (bus.busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        while (bus.busy && cnt < 40) begin
            stepClk();
            cnt++;
            saw_busy = 1'b1;
        end
        checkOutput("glitch_saw_busy", saw_busy, 1'b1);
        checkOutput("glitch_busy_drop", cnt <= 12, 1'b1);
        idle(20);
        checkOutput("glitch_no_valid", seen_valid_cycles, base_valid);
        checkOutput("glitch_no_frame", seen_frame_err, exp_frame_err);

        // Bad stop bit, line held low (break), then recovery
        $display("[TB] framing error and break");
        applyStimulus(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (24) stepClk();
        checkOutput("break_busy",  bus.busy, 1'b1);
        checkOutput("break_valid", bus.valid, 1'b0);
        checkOutput("break_frame", seen_frame_err, exp_frame_err);
        idle(8);
        checkOutput("break_exit", bus.busy, 1'b0);
        applyStimulus(8'h55, 1'b1);
        idle(20);

        // Consumer stalled: first byte held, second is an overrun
        $display("[TB] overrun");
        rdy_mode  = 1;
        bus.ready = 1'b0;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        idle(20);
        checkOutput("ovr_valid", bus.valid, 1'b1);
        checkOutput("ovr_data",  bus.data, 8'h11);
        checkOutput("ovr_count", seen_overrun, exp_overrun);
        rdy_mode  = 0;
        holding   = 1'b0;
        bus.ready = 1'b1;
        stepClk();
        stepClk();
        checkOutput("ovr_drained", bus.valid, 1'b0);

        // Back-to-back frames, then reset in the middle of a fourth
        $display("[TB] back-to-back and mid-frame reset");
        base_valid = seen_valid_cycles;
        base_xfer  = seen_transfers;
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h81, 1'b1);
        idle(4);
        checkOutput("b2b_transfers",   seen_transfers - base_xfer, 3);
        checkOutput("b2b_valid_pulse", seen_valid_cycles - base_valid, 3);
        checkOutput("b2b_frame",       seen_frame_err, exp_frame_err);
        checkOutput("b2b_overrun",     seen_overrun, exp_overrun);
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_data",    bus.data, 8'h00);
        checkOutput("midrst_valid",   bus.valid, 1'b0);
        checkOutput("midrst_busy",    bus.busy, 1'b0);
        checkOutput("midrst_frame",   bus.frame_err, 1'b0);
        checkOutput("midrst_overrun", bus.overrun_err, 1'b0);
        repeat (3) stepClk();
        rx  = 1'b1;
        rst = 1'b1;
        base_valid = seen_valid_cycles;
        idle(200);
        checkOutput("midrst_no_valid", seen_valid_cycles, base_valid);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity needs a 1 on the line
        $display("[TB] parity");
        exp_parity_err++;
        modelCommit(8'h07);
        driveFrame(8'h07, 1'b0, 1'b1, 1'b1);
        idle(10);
        checkOutput("par_bad_pulse", seen_parity_err, exp_parity_err);
        modelCommit(8'h07);
        driveFrame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(10);
        checkOutput("par_good_quiet", seen_parity_err, exp_parity_err);
`endif

        // Random bytes with a jittery consumer and occasional bad stop bits
        $display("[TB] random stream");
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 7) != 0);
            applyStimulus(rb, rstop);
            idle(rstop ? $urandom_range(0, 6) : $urandom_range(4, 10));
        end
        rdy_mode  = 0;
        bus.ready = 1'b1;
        idle(50);

        checkOutput("end_queue_empty", exp_q.size(), 0);
        checkOutput("end_frame_err",   seen_frame_err, exp_frame_err);
        checkOutput("end_overrun",     seen_overrun, exp_overrun);
        checkOutput("end_parity_err",  seen_parity_err, exp_parity_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
